// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring divide, with registered result and flags.
module alu_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   control,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);
    localparam int CW = $clog2(N) + 1;
    localparam int SW = $clog2(N);
    localparam logic [N-1:0] LP_NM1 = N'(N - 1);

    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_AND = 4'd1, OP_OR = 4'd2, OP_XOR = 4'd3, OP_RSV = 4'd4,
        OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_ADD = 4'd8, OP_MUL = 4'd9,
        OP_MULHU = 4'd10, OP_DIVU = 4'd11, OP_SUB = 4'd12, OP_SLT = 4'd13,
        OP_REMU = 4'd14, OP_SLTU = 4'd15
    } alu_control_t;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    alu_control_t   r_op;
    logic [2*N-1:0] r_acc;
    logic [N-1:0]   r_rem;
    logic [N-1:0]   r_q;

    alu_control_t   w_op;
    logic           w_accept;
    logic [N-1:0]   w_sum;
    logic [N-1:0]   w_diff;
    logic [SW-1:0]  w_sh;
    logic           w_big;
    logic [N-1:0]   w_alu_res;
    logic           w_alu_ovf;
    logic [N:0]     w_mul_sum;
    logic [2*N-1:0] w_mul_next;
    logic [N:0]     w_div_sh;
    logic [N:0]     w_div_trial;
    logic [N-1:0]   w_rem_next;
    logic [N-1:0]   w_q_next;
    logic           w_last;
    logic [N-1:0]   w_fin_res;

    assign w_op     = alu_control_t'(control);
    assign in_ready = (r_state == S_IDLE) && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_sum    = a + b;
    assign w_diff   = a - b;
    assign w_sh     = b[SW-1:0];
    assign w_big    = (b > LP_NM1);

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (w_op)
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_SLL:  w_alu_res = w_big ? '0 : (a << w_sh);
            OP_SRL:  w_alu_res = w_big ? '0 : (a >> w_sh);
            OP_SRA:  w_alu_res = w_big ? {N{a[N-1]}} : N'($signed(a) >>> w_sh);
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
            end
            OP_SLT:  w_alu_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu_res = {{(N-1){1'b0}}, (a < b)};
            default: w_alu_res = '0;
        endcase
    end

    // Multiplier: upper half accumulates partial sums, lower half shifts out multiplier bits.
    assign w_mul_sum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[N-1:1]};

    // Restoring divider: a zero divisor always "fits", giving all-ones quotient and remainder a.
    assign w_div_sh    = {r_rem, r_q[N-1]};
    assign w_div_trial = w_div_sh - {1'b0, r_b};
    assign w_rem_next  = w_div_trial[N] ? w_div_sh[N-1:0] : w_div_trial[N-1:0];
    assign w_q_next    = {r_q[N-2:0], ~w_div_trial[N]};

    assign w_last = (r_cnt == CW'(N - 1));

    always_comb begin
        w_fin_res = '0;
        case (r_op)
            OP_MUL:   w_fin_res = w_mul_next[N-1:0];
            OP_MULHU: w_fin_res = w_mul_next[2*N-1:N];
            OP_DIVU:  w_fin_res = w_q_next;
            OP_REMU:  w_fin_res = w_rem_next;
            default:  w_fin_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            equal     <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_op <= w_op;
                        if (w_op == OP_MUL || w_op == OP_MULHU) begin
                            r_cnt   <= '0;
                            r_acc   <= {{N{1'b0}}, b};
                            r_state <= S_MUL;
                        end else if (w_op == OP_DIVU || w_op == OP_REMU) begin
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_q     <= a;
                            r_state <= S_DIV;
                        end else begin
                            result    <= w_alu_res;
                            overflow  <= w_alu_ovf;
                            zero      <= (w_alu_res == '0);
                            equal     <= (a == b);
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        result    <= w_fin_res;
                        overflow  <= 1'b0;
                        zero      <= (w_fin_res == '0);
                        equal     <= (r_a == r_b);
                        out_valid <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        result    <= w_fin_res;
                        overflow  <= (r_b == '0);
                        zero      <= (w_fin_res == '0);
                        equal     <= (r_a == r_b);
                        out_valid <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes hand-computed expectations,
// a monitor pops and compares on every consumed result.
module tb_alu_seq;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   control;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         overflow;
    logic         zero;
    logic         equal;

    typedef struct {
        logic [N-1:0] res;
        logic         ovf;
        logic         z;
        logic         eq;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow),
        .zero(zero), .equal(equal)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [N-1:0] r, input logic o, input logic z,
                                input logic e, input string n);
        exp_t x;
        x.res = r; x.ovf = o; x.z = z; x.eq = e; x.name = n;
        return x;
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: a result is consumed on the next rising edge when valid and ready are both high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none", result);
                end else begin
                    e = sb.pop_front();
                    if ({result, overflow, zero, equal} !== {e.res, e.ovf, e.z, e.eq}) begin
                        errors++;
                        $display("FAIL %s actual res=%h ovf=%b z=%b eq=%b required res=%h ovf=%b z=%b eq=%b",
                                 e.name, result, overflow, zero, equal, e.res, e.ovf, e.z, e.eq);
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic push, input exp_t e);
        int guard = 0;
        in_valid = 1'b1; control = op; a = av; b = bv;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles of in_ready low after an accept; expected to equal N for iterative ops.
    task automatic check_latency(input string name);
        int cnt = 0;
        while (in_ready !== 1'b1 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        check(name, N'(cnt), N'(N));
        check({name, "_vld"}, N'(out_valid), N'(1));
    endtask

    initial begin
        exp_t dummy;
        int   seen;
        dummy = mk('0, 1'b0, 1'b0, 1'b0, "none");
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; control = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", N'(out_valid), N'(0));
        check("rst_result", result, N'(0));
        check("rst_flags", N'({overflow, zero, equal}), N'(0));
        check("rst_in_ready", N'(in_ready), N'(1));

        send(4'd8, 32'h7FFF_FFFF, 32'h1, 1'b1, mk(32'h8000_0000, 1'b1, 1'b0, 1'b0, "add_ovf"));
        check("add_latency", N'(out_valid), N'(1));

        send(4'd12, 32'd5, 32'd5, 1'b1, mk(32'h0, 1'b0, 1'b1, 1'b1, "sub_zero"));
        send(4'd13, 32'hFFFF_FFFF, 32'h1, 1'b1, mk(32'h1, 1'b0, 1'b0, 1'b0, "slt_neg"));
        send(4'd15, 32'hFFFF_FFFF, 32'h1, 1'b1, mk(32'h0, 1'b0, 1'b1, 1'b0, "sltu_big"));
        send(4'd7, 32'h8000_0000, 32'd40, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "sra_big"));
        send(4'd5, 32'h0000_0003, 32'd4, 1'b1, mk(32'h30, 1'b0, 1'b0, 1'b0, "sll_4"));
        send(4'd6, 32'hFFFF_FFFF, 32'd32, 1'b1, mk(32'h0, 1'b0, 1'b1, 1'b0, "srl_big"));

        send(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, "mulhu"));
        check_latency("mulhu_lat");
        send(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(32'h1, 1'b0, 1'b0, 1'b1, "mul"));
        check_latency("mul_lat");
        send(4'd11, 32'd100, 32'd7, 1'b1, mk(32'd14, 1'b0, 1'b0, 1'b0, "divu"));
        check_latency("divu_lat");
        send(4'd14, 32'd100, 32'd7, 1'b1, mk(32'd2, 1'b0, 1'b0, 1'b0, "remu"));
        check_latency("remu_lat");
        send(4'd11, 32'd9, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "divu_by0"));
        check_latency("divu0_lat");
        send(4'd14, 32'd9, 32'd0, 1'b1, mk(32'd9, 1'b1, 1'b0, 1'b0, "remu_by0"));
        check_latency("remu0_lat");

        // Back-pressure: result must hold while a competing op waits unaccepted.
        send(4'd3, 32'hF0F0, 32'hFFFF, 1'b1, mk(32'h0F0F, 1'b0, 1'b0, 1'b0, "xor_hold"));
        out_ready = 1'b0;
        in_valid = 1'b1; control = 4'd8; a = 32'd1; b = 32'd1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("hold_result", result, 32'h0F0F);
            check("hold_in_ready", N'({out_valid, in_ready}), N'(2'b10));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", N'(in_ready), N'(1));
        send(4'd8, 32'd1, 32'd1, 1'b1, mk(32'd2, 1'b0, 1'b0, 1'b1, "add_after_hold"));

        // Reset in the middle of a divide: nothing may emerge from it.
        send(4'd11, 32'd100, 32'd7, 1'b0, dummy);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", N'(out_valid), N'(0));
        check("midrst_result", result, N'(0));
        check("midrst_in_ready", N'(in_ready), N'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        check("midrst_no_stale", N'(seen), N'(0));
        send(4'd1, 32'hFF00, 32'h0FF0, 1'b1, mk(32'h0F00, 1'b0, 1'b0, 1'b0, "and_after_rst"));

        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("sb_drained", N'(sb.size()), N'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
